// File: rtl/gray_step_decoder.sv
// rtl/gray_step_decoder.sv - synchronises a gray-coded count, decodes it to binary and tracks +1/-1 steps
module gray_step_decoder #(
  parameter int W           = 2,
  parameter int POS_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     gray_in,
  input  logic             clr,
  output logic [W-1:0]     bin_out,
  output logic             step_up,
  output logic             step_dn,
  output logic [POS_W-1:0] pos,
  output logic             err,
  output logic             locked
);

  localparam int            CW       = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] LOCK_CNT = CW'(SYNC_STAGES);
  localparam logic [W-1:0]  DIFF_UP  = W'(1);
  localparam logic [W-1:0]  DIFF_DN  = {W{1'b1}};

  typedef enum logic [1:0] {UNLOCKED, LOCKED, FAULT} state_t;

  state_t                            state, state_next;
  logic [SYNC_STAGES-1:0][W-1:0]     sync_q;
  logic [W-1:0]                      s, cur, prev, diff;
  logic [CW-1:0]                     cnt, cnt_next;
  logic [W-1:0]                      prev_next, bin_next;
  logic [POS_W-1:0]                  pos_next;
  logic                              err_next, up_next, dn_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], gray_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Binary bit i is the XOR of all gray bits at or above i.
  always_comb begin
    cur = s;
    for (int k = 1; k < W; k++) cur = cur ^ (s >> k);
  end

  assign diff   = cur - prev;
  assign locked = (state == LOCKED);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    prev_next  = prev;
    bin_next   = bin_out;
    pos_next   = pos;
    err_next   = err;
    up_next    = 1'b0;
    dn_next    = 1'b0;
    case (state)
      UNLOCKED: begin
        if (clr) pos_next = '0;
        if (cnt == LOCK_CNT) begin
          prev_next  = cur;
          bin_next   = cur;
          cnt_next   = '0;
          state_next = LOCKED;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      LOCKED: begin
        bin_next  = cur;
        prev_next = cur;
        if (clr) begin
          pos_next = '0;
        end else if (diff == DIFF_UP) begin
          up_next  = 1'b1;
          pos_next = pos + POS_W'(1);
        end else if (diff == DIFF_DN) begin
          dn_next  = 1'b1;
          pos_next = pos - POS_W'(1);
        end else if (diff != '0) begin
          err_next   = 1'b1;
          state_next = FAULT;
        end
      end
      FAULT: begin
        // prev is frozen here; only clr re-establishes a reference via re-lock.
        bin_next = cur;
        if (clr) begin
          pos_next   = '0;
          err_next   = 1'b0;
          cnt_next   = '0;
          state_next = UNLOCKED;
        end
      end
      default: begin
        state_next = UNLOCKED;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= UNLOCKED;
      cnt     <= '0;
      prev    <= '0;
      bin_out <= '0;
      pos     <= '0;
      err     <= 1'b0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      prev    <= prev_next;
      bin_out <= bin_next;
      pos     <= pos_next;
      err     <= err_next;
      step_up <= up_next;
      step_dn <= dn_next;
    end
  end

endmodule

// File: doc/gray_step_decoder.md
Name: gray_step_decoder

Overview:
- Receiving end of the team's gray-coded counter interface.
- Takes a W-bit gray code that may come from another clock domain or a free-running generator, and synchronises it.
- Converts it to binary and classifies each change as a step up, a step down or an illegal jump.
- Maintains a signed-agnostic position accumulator. Sits downstream of a gray counter FSM or encoder as its consumer/checker.

Parameters:
- W, 2, gray/binary code width; legal range W >= 2.
- POS_W, 8, position accumulator width.
- SYNC_STAGES, 2, synchroniser flop count on gray_in; legal range >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- gray_in  input  W  gray-coded count; may be asynchronous to clk.
- clr  input  1  synchronous clear: zero pos, clear err, re-lock from FAULT.
- bin_out  output  W  registered binary equivalent of the synchronised gray_in.
- step_up  output  1  one-cycle pulse per +1 step.
- step_dn  output  1  one-cycle pulse per -1 step.
- pos  output  POS_W  running position, modulo 2^POS_W.
- err  output  1  sticky illegal-transition flag.
- locked  output  1  high while FSM is in LOCKED.

Behaviour:
- Reset (rst=1, asynchronous):
  - sync chain, prev, bin_out and pos are all 0.
  - step_up=0, step_dn=0, err=0, locked=0.
  - lock counter 0; FSM in UNLOCKED.
- Synchroniser: SYNC_STAGES flops in series; the last stage is s.
- Conversion (combinational from s):
  - cur[W-1] = s[W-1].
  - cur[i] = cur[i+1] ^ s[i], for i from W-2 down to 0.
- Difference: diff = (cur - prev) mod 2^W, computed at W bits.
- step_up and step_dn are registered and each is high for exactly one cycle per event. They are never both high.
- FSM states: UNLOCKED, LOCKED, FAULT.
- UNLOCKED:
  - Lock counter increments each edge.
  - When it equals SYNC_STAGES: prev <= cur, bin_out <= cur, go to LOCKED.
  - No step or err is generated while UNLOCKED.
  - Exit occurs at the (SYNC_STAGES+1)th edge after reset release.
- LOCKED, every edge:
  - bin_out <= cur and prev <= cur.
  - diff = 0: no pulse.
  - diff = 1: step_up=1, pos <= pos + 1.
  - diff = 2^W-1: step_dn=1, pos <= pos - 1.
  - Any other diff: err <= 1, no pulse, pos held, go to FAULT.
- FAULT:
  - bin_out keeps tracking cur; prev is not updated.
  - No step pulses; pos is held; err stays 1; locked=0.
- clr has priority over step and error detection in the same cycle:
  - pos <= 0 and no pulse.
  - In LOCKED, prev <= cur and the FSM stays LOCKED.
  - In FAULT, err <= 0, lock counter cleared, go to UNLOCKED.
  - In UNLOCKED, pos <= 0 and locking continues.
- Latency: a gray_in change that is stable before edge 1 shows on bin_out and step_up/step_dn after edge SYNC_STAGES+1. With the default SYNC_STAGES this is 3 edges.
- Wrap-around:
  - Code wrap, e.g. 2^W-1 to 0, is a legal +1 step by the modular diff.
  - pos wraps modulo 2^POS_W in both directions with no flag.
- Input rate: gray_in must change at most once per clk cycle. Faster changes are indistinguishable from illegal jumps and are reported as err.
- Reset mid-operation: any state returns to reset values immediately. Re-lock then takes SYNC_STAGES+1 edges.

Test Plan:
- Reset then hold gray_in=00 (W=2) for 5 cycles:
  - locked rises at edge 3.
  - err=0, pos=0, no pulses.
- Up sequence 00,01,11,10,00, one code per 4 cycles, after lock:
  - bin_out goes 0,1,2,3,0.
  - Four step_up pulses, each 3 edges after its change.
  - pos=4, step_dn never asserted.
- Down sequence 00,10,11,01 from pos=4:
  - Three step_dn pulses.
  - bin_out goes 3,2,1; pos=1.
- Illegal jump 00->11 (binary 0->2) while LOCKED:
  - err=1, locked=0, no pulse, pos unchanged.
  - Further legal steps ignored.
  - clr for one cycle: err=0, pos=0, locked=1 again SYNC_STAGES+1 edges later.
- Wrap with POS_W=8: preload 255 up-steps via the up sequence, then one more step_up.
  - pos=0, err=0.
  - Then one step_dn: pos=255.
- Edge cases:
  - Assert rst asynchronously mid-sequence with pos=7: all outputs zero immediately.
  - clr coincident with a step_up event: pos=0 and no pulse.
